uart_rx_fifo: RTL and testbench

- Receive-side byte buffer placed directly downstream of uart_rx.
- Captures each byte uart_rx reports (rx_d strobe with rx_rec data) into a show-ahead (first-word-fall-through) FIFO.
- Presents bytes to the host/consumer over a valid/ready handshake.
- Reports occupancy, full/empty, a sticky overflow flag and a saturating dropped-byte count.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_fifo_mem.sv | 34 +++
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared UART constants and a saturating-increment helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W       = 8;
    // 50 MHz system clock at 9600 baud
    localparam int UART_CLKS_PER_BIT = 5208;
    localparam int DROP_CNT_W        = 8;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
//------------------------------------------------------------------------------
// Module   : uart_fifo_mem
// Brief    : DEPTH x DATA_W simple dual-port array, registered write and
//            combinational read address.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_fifo
// Brief    : Show-ahead receive FIFO behind uart_rx with valid/ready read side,
//            occupancy flags, sticky overflow and saturating drop counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_d,
    input  logic [DATA_W-1:0]     rx_rec,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_W:0]       count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_valid;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [ADDR_W:0]       w_count_nxt;
    logic [DATA_W-1:0]     w_mem_rdata;

    // A pop in the same cycle frees the slot, so a strobe while full still lands
    assign w_pop  = r_valid & rd_ready;
    assign w_push = rx_d & (~r_full | w_pop);
    assign w_drop = rx_d & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
            r_empty <= (w_count_nxt == '0);
            r_valid <= (w_count_nxt != '0);
        end
    end

    // A drop in the same cycle as a clear restarts the count at one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= ovf_clr ? DROP_CNT_W'(1) : sat_inc(r_drop_cnt);
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .we     (w_push),
        .waddr  (r_wr_ptr),
        .wdata  (rx_rec),
        .raddr  (r_rd_ptr),
        .rdata  (w_mem_rdata)
    );

    assign rd_valid = r_valid;
    assign rd_data  = r_valid ? w_mem_rdata : '0;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_rx_fifo
// Brief    : Scoreboard bench for uart_rx_fifo (DEPTH=4) with queue reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_d;
    logic [7:0]       rx_rec;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_ready;
    logic [ADDR_W:0]  count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             ovf_clr;
    logic [7:0]       drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference: queue of bytes currently held, plus overflow flag and drop count
    logic [7:0] m_q[$];
    logic       m_ovf;
    int         m_drop;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_d     (rx_d),
        .rx_rec   (rx_rec),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .drop_cnt (drop_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: head must match the oldest queued byte; a handshake retires it
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            chk("head_present", int'(m_q.size() != 0), 1);
            if (m_q.size() != 0) begin
                chk("rd_data", int'(rd_data), int'(m_q[0]));
                if (rd_ready) begin
                    void'(m_q.pop_front());
                end
            end
        end
    end

    task automatic check_state();
        chk("count",    int'(count),    m_q.size());
        chk("rd_valid", int'(rd_valid), int'(m_q.size() != 0));
        chk("empty",    int'(empty),    int'(m_q.size() == 0));
        chk("full",     int'(full),     int'(m_q.size() == DEPTH));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("drop_cnt", int'(drop_cnt), m_drop);
        if (m_q.size() == 0) begin
            chk("rd_data_idle", int'(rd_data), 0);
        end
    endtask

    task automatic cyc(input logic rx, input logic [7:0] d, input logic rdy, input logic clr);
        logic pop_m;
        logic acc;
        @(posedge clk);
        #1 check_state();
        #1;
        rst      = 1'b0;
        rx_d     = rx;
        rx_rec   = d;
        rd_ready = rdy;
        ovf_clr  = clr;
        pop_m = rdy && (m_q.size() != 0);
        acc   = rx && ((m_q.size() < DEPTH) || pop_m);
        if (acc) begin
            m_q.push_back(d);
        end
        if (rx && !acc) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endtask

    task automatic reset_with_strobe();
        @(posedge clk);
        #1 check_state();
        #1;
        rst      = 1'b1;
        rx_d     = 1'b1;
        rx_rec   = 8'hEE;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rx_d = 1'b0; rx_rec = 8'h00; rd_ready = 1'b0; ovf_clr = 1'b0;
        m_ovf = 1'b0; m_drop = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        // single byte, then consume
        cyc(1, 8'hA5, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);

        // ordering under a stalled reader
        cyc(1, 8'hA5, 0, 0);
        cyc(1, 8'h3C, 0, 0);
        cyc(1, 8'hF0, 0, 0);
        repeat (4) cyc(0, 8'h00, 1, 0);

        // overflow: five strobes into four slots
        for (int i = 1; i <= 5; i++) cyc(1, 8'(i), 0, 0);
        repeat (5) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);

        // full with a simultaneous read accepts the byte
        for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'h55, 1, 0);
        repeat (5) cyc(0, 8'h00, 1, 0);

        // streaming push/pop across pointer wrap
        for (int i = 0; i < 40; i++) cyc(1, 8'(i + 8'h10), 1, 0);
        repeat (2) cyc(0, 8'h00, 1, 0);

        // drop counter saturation, then clear coinciding with a drop
        for (int i = 0; i < 4; i++) cyc(1, 8'(i + 8'h80), 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 8'hDD, 0, 0);
        cyc(1, 8'hDE, 0, 1);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 1);
        repeat (5) cyc(0, 8'h00, 1, 0);

        // reset with three bytes queued and a strobe in the reset cycle
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        reset_with_strobe();
        cyc(1, 8'h7E, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(logic'($urandom_range(0, 99) < 55), 8'($urandom),
                logic'($urandom_range(0, 99) < 45), logic'($urandom_range(0, 39) == 0));
        end
        repeat (6) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
